// File: rtl/regfile_cache_port_lsu_pkg.sv
// Shared definitions for the regfile/cache load-store sequencer:
// FSM state encodings, op-type constants and the data width.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package regfile_cache_port_lsu_pkg;

    typedef enum logic [2:0] {
        LSU_IDLE  = 3'd0,
        LSU_FETCH = 3'd1,
        LSU_ISSUE = 3'd2,
        LSU_WAIT  = 3'd3,
        LSU_WB    = 3'd4
    } lsu_state_e;

    localparam logic OP_STORE = 1'b1;
    localparam logic OP_LOAD  = 1'b0;

    // Stores need a regfile read cycle before the cache request; loads go straight to issue.
    function automatic lsu_state_e first_state(input logic op);
        return (op == OP_STORE) ? LSU_FETCH : LSU_ISSUE;
    endfunction

endpackage

// File: rtl/lsu_timeout_counter.sv
// Wait-cycle counter for the LSU. `expire` flags that the current WAIT
// cycle is the last one allowed before the request is abandoned.
module lsu_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // Count is independent of `inc` so the FSM can consult it without a combinational loop.
    assign expire = (count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Cycle counter: cleared at request issue, stepped while waiting, frozen when disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            if (clear) begin
                count <= '0;
            end else if (inc) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_cache_port_lsu.sv
// Load/store sequencer between the PE register file cache port and the
// data cache. Stores read a register and write it to the cache; loads read
// the cache and write the result back into the register file.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module regfile_cache_port_lsu
    import regfile_cache_port_lsu_pkg::*;
#(
    parameter int REGFILE_ADDR_WIDTH = 4,
    parameter int CACHE_ADDR_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                          CLK_I,
    input  logic                          RST_N_I,
    input  logic                          EN_I,
    input  logic                          START_I,
    input  logic                          OP_STORE_I,
    input  logic [REGFILE_ADDR_WIDTH-1:0] REG_IDX_I,
    input  logic [CACHE_ADDR_WIDTH-1:0]   BASE_ADDR_I,
    input  logic [CACHE_ADDR_WIDTH-1:0]   OFFSET_I,
    output logic [REGFILE_ADDR_WIDTH-1:0] RD_PORT_CACHE_ADDR_O,
    input  logic [`DATA_WIDTH-1:0]        RD_PORT_CACHE_I,
    output logic                          WR_PORT_EN_O,
    output logic [REGFILE_ADDR_WIDTH-1:0] WR_PORT_ADDR_O,
    output logic [`DATA_WIDTH-1:0]        WR_PORT_DATA_O,
    output logic                          CACHE_VALID_O,
    output logic                          CACHE_WR_O,
    output logic [CACHE_ADDR_WIDTH-1:0]   CACHE_ADDR_O,
    output logic [`DATA_WIDTH-1:0]        CACHE_DATA_O,
    input  logic                          CACHE_ACK_I,
    input  logic [`DATA_WIDTH-1:0]        CACHE_DATA_I,
    output logic                          BUSY_O,
    output logic                          DONE_O,
    output logic                          ERR_O
);

    localparam int DW = `DATA_WIDTH;

    lsu_state_e state;
    lsu_state_e state_nxt;

    logic                        op_q;
    logic [CACHE_ADDR_WIDTH-1:0] addr_q;
    logic [DW-1:0]               load_data;
    logic [CACHE_ADDR_WIDTH-1:0] addr_sum;

    logic do_accept;
    logic do_fetch;
    logic do_issue;
    logic do_store_done;
    logic do_load_ack;
    logic do_timeout;
    logic do_wb;
    logic cnt_clear;
    logic cnt_inc;
    logic cnt_expire;

    // Offset is two's complement; the sum wraps at the address width.
    assign addr_sum = BASE_ADDR_I + OFFSET_I;
    assign BUSY_O   = (state != LSU_IDLE);

    lsu_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (CLK_I),
        .rst_n (RST_N_I),
        .en    (EN_I),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .expire(cnt_expire)
    );

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            state <= LSU_IDLE;
        end else if (EN_I) begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state action strobes.
    always_comb begin
        state_nxt     = state;
        do_accept     = 1'b0;
        do_fetch      = 1'b0;
        do_issue      = 1'b0;
        do_store_done = 1'b0;
        do_load_ack   = 1'b0;
        do_timeout    = 1'b0;
        do_wb         = 1'b0;
        cnt_clear     = 1'b0;
        cnt_inc       = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (START_I) begin
                    do_accept = 1'b1;
                    state_nxt = first_state(OP_STORE_I);
                end
            end
            LSU_FETCH: begin
                do_fetch  = 1'b1;
                state_nxt = LSU_ISSUE;
            end
            LSU_ISSUE: begin
                do_issue  = 1'b1;
                cnt_clear = 1'b1;
                state_nxt = LSU_WAIT;
            end
            LSU_WAIT: begin
                cnt_inc = 1'b1;
                // An acknowledge on the expiry cycle still completes the op.
                if (CACHE_ACK_I) begin
                    if (op_q == OP_LOAD) begin
                        do_load_ack = 1'b1;
                        state_nxt   = LSU_WB;
                    end else begin
                        do_store_done = 1'b1;
                        state_nxt     = LSU_IDLE;
                    end
                end else if (cnt_expire) begin
                    do_timeout = 1'b1;
                    state_nxt  = LSU_IDLE;
                end
            end
            LSU_WB: begin
                do_wb     = 1'b1;
                state_nxt = LSU_IDLE;
            end
            default: begin
                state_nxt = LSU_IDLE;
            end
        endcase
    end

    // Operation context captured at accept and load data captured at acknowledge.
    always_ff @(posedge CLK_I) begin
        if (EN_I) begin
            if (do_accept) begin
                op_q   <= OP_STORE_I;
                addr_q <= addr_sum;
            end
            if (do_load_ack) begin
                load_data <= CACHE_DATA_I;
            end
        end
    end

    // Registered outputs: request, regfile ports and completion pulses.
    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            RD_PORT_CACHE_ADDR_O <= '0;
            WR_PORT_EN_O         <= 1'b0;
            WR_PORT_ADDR_O       <= '0;
            WR_PORT_DATA_O       <= '0;
            CACHE_VALID_O        <= 1'b0;
            CACHE_WR_O           <= 1'b0;
            CACHE_ADDR_O         <= '0;
            CACHE_DATA_O         <= '0;
            DONE_O               <= 1'b0;
            ERR_O                <= 1'b0;
        end else if (EN_I) begin
            WR_PORT_EN_O <= do_wb;
            DONE_O       <= do_store_done | do_wb;
            ERR_O        <= do_timeout;
            if (do_accept) begin
                RD_PORT_CACHE_ADDR_O <= REG_IDX_I;
            end
            if (do_fetch) begin
                CACHE_DATA_O <= RD_PORT_CACHE_I;
            end
            if (do_issue) begin
                CACHE_VALID_O <= 1'b1;
                CACHE_WR_O    <= op_q;
                CACHE_ADDR_O  <= addr_q;
            end else if (do_store_done | do_load_ack | do_timeout) begin
                CACHE_VALID_O <= 1'b0;
            end
            // The read index register doubles as the latched load destination.
            if (do_wb) begin
                WR_PORT_ADDR_O <= RD_PORT_CACHE_ADDR_O;
                WR_PORT_DATA_O <= load_data;
            end
        end
    end

endmodule
